pipe_control: RTL
=================

// Module: pipe_control
// PURPOSE
//  Hazard/sequencing controller for the 5-stage Y86-64 pipeline. Drives per-stage stall/bubble,
//  gates and holds the condition-code register (ZF/SF/OF) fed by the execute-stage ALU,
//  runs a run/halt state machine on the write-back status, and keeps saturating perf counters.
//  Sits beside the F/D/E/M/W pipeline registers; all stage registers obey its controls.
// PARAMETERS
//  CNT_W  32  width of cycle/stall/bubble perf counters (saturating)
//  RNONE  15  register ID meaning "no register"
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      synchronous, active-high reset
//  D_icode     in   4      icode in decode register
//  d_srcA      in   4      decode srcA
//  d_srcB      in   4      decode srcB
//  E_icode     in   4      icode in execute register
//  E_dstM      in   4      execute dstM
//  e_cnd       in   1      branch/cmov condition from execute
//  alu_zf      in   1      ZF computed by execute ALU this cycle
//  alu_sf      in   1      SF computed by execute ALU this cycle
//  alu_of      in   1      OF computed by execute ALU this cycle
//  M_icode     in   4      icode in memory register
//  m_stat      in   2      memory-stage status (0 AOK,1 HLT,2 ADR,3 INS)
//  W_stat      in   2      write-back status, same encoding
//  F_stall     out  1      hold fetch PC register
//  D_stall     out  1      hold decode register
//  D_bubble    out  1      load nop into decode register
//  E_bubble    out  1      load nop into execute register
//  M_bubble    out  1      load nop into memory register
//  W_stall     out  1      hold write-back register
//  set_cc      out  1      CC register write enable this cycle
//  ZF,SF,OF    out  1 ea   registered condition codes
//  halted      out  1      pipeline frozen in HALT
//  halt_code   out  2      W_stat captured on HALT entry
//  cycle_cnt, stall_cnt, bubble_cnt  out  CNT_W  perf counters
// BEHAVIOUR
//  Reset: state=INIT; ZF=1,SF=0,OF=0; halted=0; halt_code=0; all counters=0.
//  FSM: INIT --1 cycle--> RUN; RUN --W_stat!=0--> HALT; HALT sticky until rst. rst wins over all.
//  INIT: F_stall=1, D/E/M_bubble=1, W_stall=0, set_cc=0 (flushes garbage after reset).
//  RUN hazard terms (combinational, same cycle):
//   loaduse = E_icode in {5 mrmovq,11 popq} && E_dstM!=RNONE && E_dstM in {d_srcA,d_srcB}
//   ret     = 9 in {D_icode,E_icode,M_icode};  mispred = E_icode==7 && !e_cnd
//   F_stall = loaduse|ret;  D_stall = loaduse;  D_bubble = mispred | (ret & !loaduse)
//   E_bubble = mispred|loaduse;  M_bubble = m_stat!=0 | W_stat!=0;  W_stall = W_stat!=0
//   D_stall and D_bubble never both 1; mispred+loaduse together -> E_bubble only once, D_bubble=1.
//  set_cc = RUN && E_icode==6 && m_stat==0 && W_stat==0. On clk with set_cc: {ZF,SF,OF}<={alu_*};
//   else hold. Flags visible to execute one cycle after the OPq leaves E (1-cycle latency).
//  HALT: entered on edge where W_stat!=0 in RUN; halt_code<=W_stat that edge. In HALT:
//   F_stall=D_stall=W_stall=1, M_bubble=1, E_bubble=0, D_bubble=0, set_cc=0; halted=1 registered.
//  Counters (RUN only, frozen in INIT/HALT): cycle_cnt+1 every cycle; stall_cnt+1 when F_stall|D_stall;
//   bubble_cnt+1 when any of D/E/M_bubble. Each saturates at 2^CNT_W-1, no wrap.
// TESTING
//  rst 1 cycle -> INIT: F_stall=1,D/E/M_bubble=1; next cycle RUN, all controls 0, ZF=1.
//  E_icode=5,E_dstM=3,d_srcA=3 -> F_stall=1,D_stall=1,E_bubble=1,D_bubble=0; E_dstM=15 -> all 0.
//  E_icode=7,e_cnd=0,D_icode=9 -> D_bubble=1,E_bubble=1,F_stall=1; stall_cnt and bubble_cnt +1.
//  E_icode=6,alu={zf0,sf1,of1},stats AOK -> next clk SF=1,OF=1,ZF=0; same with m_stat=2 -> CC held.
//  W_stat=1 in RUN -> next cycle halted=1,halt_code=1,F/D/W_stall=1, counters frozen; rst -> INIT.
//  CNT_W=4, run 20 cycles -> cycle_cnt stays 15.

Source files
------------

// File: rtl/pipe_control.sv
// Hazard and sequencing controller for a 5-stage Y86-64 pipeline.
// Produces stage stall/bubble controls, owns the condition codes, tracks run/halt, and keeps perf counters.
module pipe_control #(
    parameter int         CNT_W = 32,
    parameter logic [3:0] RNONE = 4'd15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_cnd,
    input  logic             alu_zf,
    input  logic             alu_sf,
    input  logic             alu_of,
    input  logic [3:0]       M_icode,
    input  logic [1:0]       m_stat,
    input  logic [1:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             set_cc,
    output logic             ZF,
    output logic             SF,
    output logic             OF,
    output logic             halted,
    output logic [1:0]       halt_code,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [3:0] I_OPQ    = 4'd6;
    localparam logic [3:0] I_JXX    = 4'd7;
    localparam logic [3:0] I_MRMOVQ = 4'd5;
    localparam logic [3:0] I_RET    = 4'd9;
    localparam logic [3:0] I_POPQ   = 4'd11;

    state_t state;
    state_t state_next;
    logic   loaduse;
    logic   ret_haz;
    logic   mispred;
    logic   w_bad;
    logic   m_bad;

    assign loaduse = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) && (E_dstM != RNONE) &&
                     ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign ret_haz = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    assign mispred = (E_icode == I_JXX) && !e_cnd;
    assign w_bad   = (W_stat != 2'd0);
    assign m_bad   = (m_stat != 2'd0);

    assign fsm_state = state;
    assign halted    = (state == S_HALT);

    always_ff @(posedge clk) begin
        if (rst) state <= S_INIT;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        F_stall    = 1'b0;
        D_stall    = 1'b0;
        D_bubble   = 1'b0;
        E_bubble   = 1'b0;
        M_bubble   = 1'b0;
        W_stall    = 1'b0;
        set_cc     = 1'b0;
        unique case (state)
            S_INIT: begin
                // Flush whatever the stage registers held coming out of reset.
                state_next = S_RUN;
                F_stall    = 1'b1;
                D_bubble   = 1'b1;
                E_bubble   = 1'b1;
                M_bubble   = 1'b1;
            end
            S_RUN: begin
                if (w_bad) state_next = S_HALT;
                F_stall  = loaduse | ret_haz;
                D_stall  = loaduse;
                // A load-use stall holds decode, so a ret bubble must not also be inserted there.
                D_bubble = mispred | (ret_haz & !loaduse);
                E_bubble = mispred | loaduse;
                M_bubble = m_bad | w_bad;
                W_stall  = w_bad;
                set_cc   = (E_icode == I_OPQ) && !m_bad && !w_bad;
            end
            S_HALT: begin
                F_stall  = 1'b1;
                D_stall  = 1'b1;
                M_bubble = 1'b1;
                W_stall  = 1'b1;
            end
            default: state_next = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ZF        <= 1'b1;
            SF        <= 1'b0;
            OF        <= 1'b0;
            halt_code <= 2'd0;
        end else begin
            if (set_cc) {ZF, SF, OF} <= {alu_zf, alu_sf, alu_of};
            if (state == S_RUN && w_bad) halt_code <= W_stat;
        end
    end

    // Counters advance only while running and stick at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt  <= '0;
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else if (state == S_RUN) begin
            if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + CNT_W'(1);
            if ((F_stall | D_stall) && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if ((D_bubble | E_bubble | M_bubble) && (bubble_cnt != '1))
                bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule
